// File: rtl/irq_controller_if.sv
// Register-bus bundle shared by the peripherals: active-low strobe/write plus
// one-hot register selects, 32-bit write data and registered read data.
interface irq_controller_if;
    logic        WE_L;
    logic        AS_L;
    logic        pending_reg_select;
    logic        enable_reg_select;
    logic        claim_reg_select;
    logic        control_reg_select;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output WE_L, AS_L,
        output pending_reg_select, enable_reg_select,
        output claim_reg_select, control_reg_select,
        output data_in,
        input  data_out
    );

    modport slave (
        input  WE_L, AS_L,
        input  pending_reg_select, enable_reg_select,
        input  claim_reg_select, control_reg_select,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt aggregator: edge-captures active-low peripheral lines into PENDING,
// masks with ENABLE/GIE, and offers a lowest-index-first claim register.
module irq_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    irq_controller_if.slave    bus,
    input  logic [NUM_SRC-1:0] irq_n,
    output logic               cpu_irq
);

    logic [NUM_SRC-1:0] s1, s2, prev;
    logic [NUM_SRC-1:0] pending, enable;
    logic               gie;
    logic               as_q;

    logic [NUM_SRC-1:0] fall;
    logic [NUM_SRC-1:0] claim_onehot;
    logic [NUM_SRC-1:0] pending_next;
    logic [31:0]        claim_id;
    logic [31:0]        rd_data;
    logic               first;
    logic               rd_access;
    logic               wr_first;
    logic               any_sel;
    logic               unused_data;

    assign unused_data = ^bus.data_in;

    always_comb begin
        fall         = prev & ~s2;
        first        = ~bus.AS_L & as_q;
        rd_access    = ~bus.AS_L & bus.WE_L;
        wr_first     = first & ~bus.WE_L;
        any_sel      = bus.pending_reg_select | bus.enable_reg_select |
                       bus.claim_reg_select | bus.control_reg_select;

        // Descending scan so the lowest qualifying index wins.
        claim_id     = '0;
        claim_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i] && enable[i]) begin
                claim_id        = 32'(i + 1);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end

        rd_data = '0;
        if (bus.claim_reg_select)
            rd_data = claim_id;
        else if (bus.pending_reg_select)
            rd_data = {{(32 - NUM_SRC){1'b0}}, pending};
        else if (bus.enable_reg_select)
            rd_data = {{(32 - NUM_SRC){1'b0}}, enable};
        else if (bus.control_reg_select)
            rd_data = {31'b0, gie};

        // Clears are applied before the new edges so a coinciding edge survives.
        pending_next = pending;
        if (wr_first && bus.pending_reg_select)
            pending_next = pending_next & ~bus.data_in[NUM_SRC-1:0];
        if (first && bus.WE_L && bus.claim_reg_select)
            pending_next = pending_next & ~claim_onehot;
        pending_next = pending_next | fall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1           <= '1;
            s2           <= '1;
            prev         <= '1;
            pending      <= '0;
            enable       <= '0;
            gie          <= 1'b0;
            as_q         <= 1'b1;
            bus.data_out <= '0;
            cpu_irq      <= 1'b0;
        end else begin
            s1      <= irq_n;
            s2      <= s1;
            prev    <= s2;
            as_q    <= bus.AS_L;
            pending <= pending_next;
            if (wr_first && bus.enable_reg_select)
                enable <= bus.data_in[NUM_SRC-1:0];
            if (wr_first && bus.control_reg_select)
                gie <= bus.data_in[0];
            if (rd_access && any_sel)
                bus.data_out <= rd_data;
            cpu_irq <= gie & (|(pending & enable));
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations are queued as each access
// or sample is launched and compared when the DUT's value is taken.
module tb_irq_controller;

    localparam int NUM_SRC     = 8;
    localparam int SEL_NONE    = -1;
    localparam int SEL_PENDING = 0;
    localparam int SEL_ENABLE  = 1;
    localparam int SEL_CLAIM   = 2;
    localparam int SEL_CONTROL = 3;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] irq_n;
    logic               cpu_irq;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    irq_controller_if bus();

    irq_controller #(.NUM_SRC(NUM_SRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq_n   (irq_n),
        .cpu_irq (cpu_irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] actual);
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput(e.tag, actual, e.value);
        end
    endtask

    task automatic set_sel(input int sel);
        bus.pending_reg_select = (sel == SEL_PENDING);
        bus.enable_reg_select  = (sel == SEL_ENABLE);
        bus.claim_reg_select   = (sel == SEL_CLAIM);
        bus.control_reg_select = (sel == SEL_CONTROL);
    endtask

    // Every access starts with an idle edge so it is seen as a fresh strobe.
    task automatic bus_write(input int sel, input logic [31:0] data);
        @(negedge clk);
        bus.AS_L    = 1'b0;
        bus.WE_L    = 1'b0;
        bus.data_in = data;
        set_sel(sel);
        @(negedge clk);
        bus.AS_L = 1'b1;
        bus.WE_L = 1'b1;
        set_sel(SEL_NONE);
    endtask

    task automatic bus_read_long(input int sel, input int cycles,
                                 output logic [31:0] first_val,
                                 output logic [31:0] last_val);
        @(negedge clk);
        bus.AS_L = 1'b0;
        bus.WE_L = 1'b1;
        set_sel(sel);
        @(negedge clk);
        first_val = bus.data_out;
        repeat (cycles - 1) @(negedge clk);
        last_val = bus.data_out;
        bus.AS_L = 1'b1;
        set_sel(SEL_NONE);
    endtask

    task automatic applyStimulus(input int sel, input string tag, input logic [31:0] expected);
        logic [31:0] v, unused_last;
        sb_push(tag, expected);
        bus_read_long(sel, 1, v, unused_last);
        sb_pop_check(v);
    endtask

    task automatic sample_irq(input string tag, input logic expected);
        sb_push(tag, {31'b0, expected});
        sb_pop_check({31'b0, cpu_irq});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] first_val, last_val;

        reset   = 1'b1;
        irq_n   = '1;
        bus.AS_L = 1'b1;
        bus.WE_L = 1'b1;
        bus.data_in = '0;
        set_sel(SEL_NONE);
        #1;
        sb_push("reset_dout", 32'h0);
        sb_pop_check(bus.data_out);
        sample_irq("reset_irq", 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        applyStimulus(SEL_PENDING, "rst_pending", 32'h0);
        applyStimulus(SEL_ENABLE,  "rst_enable",  32'h0);
        applyStimulus(SEL_CONTROL, "rst_control", 32'h0);
        applyStimulus(SEL_CLAIM,   "rst_claim",   32'h0);

        // Unimplemented high bits must read back as zero.
        bus_write(SEL_ENABLE, 32'hFFFF_FFFF);
        applyStimulus(SEL_ENABLE, "enable_width", 32'h0000_00FF);
        bus_write(SEL_CONTROL, 32'hFFFF_FFFF);
        applyStimulus(SEL_CONTROL, "control_width", 32'h1);

        // Basic interrupt and latency.
        bus_write(SEL_ENABLE, 32'h01);
        bus_write(SEL_CONTROL, 32'h1);
        @(negedge clk);
        irq_n[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 sample_irq("lat_e2", 1'b0);
        @(posedge clk);
        #1 sample_irq("lat_e3", 1'b1);
        applyStimulus(SEL_PENDING, "basic_pending", 32'h01);
        applyStimulus(SEL_CLAIM,   "basic_claim",   32'h1);
        sample_irq("claim_irq_hold", 1'b1);
        @(posedge clk);
        #1 sample_irq("claim_irq_drop", 1'b0);
        applyStimulus(SEL_CLAIM, "basic_claim2", 32'h0);
        irq_n[0] = 1'b1;
        repeat (3) @(negedge clk);

        // Priority: lowest index first.
        bus_write(SEL_ENABLE, 32'hFF);
        @(negedge clk);
        irq_n[5] = 1'b0;
        irq_n[2] = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(SEL_CLAIM, "prio_1st", 32'd3);
        applyStimulus(SEL_CLAIM, "prio_2nd", 32'd6);
        applyStimulus(SEL_CLAIM, "prio_3rd", 32'd0);
        irq_n[5] = 1'b1;
        irq_n[2] = 1'b1;
        repeat (3) @(negedge clk);

        // Masking: a disabled source still pends.
        bus_write(SEL_ENABLE, 32'h00);
        @(negedge clk);
        irq_n[3] = 1'b0;
        repeat (2) @(negedge clk);
        irq_n[3] = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(SEL_PENDING, "mask_pending", 32'h08);
        sample_irq("mask_irq", 1'b0);
        applyStimulus(SEL_CLAIM, "mask_claim", 32'h0);
        bus_write(SEL_ENABLE, 32'h08);
        sample_irq("unmask_irq_w", 1'b0);
        @(posedge clk);
        #1 sample_irq("unmask_irq_w1", 1'b1);
        applyStimulus(SEL_CLAIM, "unmask_claim", 32'd4);

        // Sticky line with a long claim strobe.
        bus_write(SEL_ENABLE, 32'h01);
        @(negedge clk);
        irq_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        sample_irq("sticky_irq", 1'b1);
        sb_push("long_claim_first", 32'd1);
        sb_push("long_claim_last", 32'd0);
        bus_read_long(SEL_CLAIM, 5, first_val, last_val);
        sb_pop_check(first_val);
        sb_pop_check(last_val);
        repeat (5) @(negedge clk);
        applyStimulus(SEL_PENDING, "sticky_no_repend", 32'h0);
        sample_irq("sticky_irq_low", 1'b0);
        irq_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        irq_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(SEL_PENDING, "rearm_pending", 32'h01);
        applyStimulus(SEL_CLAIM, "rearm_claim", 32'd1);
        irq_n[0] = 1'b1;
        repeat (3) @(negedge clk);

        // Collision: detect cycle of bit 1 lines up with the W1C edge.
        @(negedge clk);
        irq_n[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        bus_write(SEL_PENDING, 32'h02);
        applyStimulus(SEL_PENDING, "collision_set_wins", 32'h02);
        bus_write(SEL_PENDING, 32'h02);
        applyStimulus(SEL_PENDING, "w1c_clears", 32'h00);
        irq_n[1] = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a read access.
        bus_write(SEL_ENABLE, 32'hFF);
        @(negedge clk);
        irq_n = '0;
        repeat (5) @(negedge clk);
        sample_irq("pre_reset_irq", 1'b1);
        bus.AS_L = 1'b0;
        bus.WE_L = 1'b1;
        set_sel(SEL_PENDING);
        @(negedge clk);
        sb_push("pre_reset_dout", 32'hFF);
        sb_pop_check(bus.data_out);
        #2 reset = 1'b1;
        #1;
        sample_irq("async_rst_irq", 1'b0);
        sb_push("async_rst_dout", 32'h0);
        sb_pop_check(bus.data_out);
        bus.AS_L = 1'b1;
        set_sel(SEL_NONE);
        irq_n = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(SEL_PENDING, "post_rst_pending", 32'h0);
        applyStimulus(SEL_ENABLE,  "post_rst_enable",  32'h0);
        applyStimulus(SEL_CONTROL, "post_rst_control", 32'h0);
        sample_irq("post_rst_irq", 1'b0);

        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
